key_token_decoder: RTL and testbench

//  Consumes the keypad scanner's debounced key events (flag pulse + 5-bit code) and turns

---
 rtl/key_token_decoder_if.sv | 22 ++
 rtl/key_token_decoder.sv | 135 +++++++++++++
 tb/tb_key_token_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/key_token_decoder_if.sv
// Key-event and token handshake bundle between keypad scanner, decoder and ALU/sequencer.
// master = environment side (drives key events and tok_ready); slave = key_token_decoder.
interface key_token_decoder_if #(
    parameter int OPW = 16
);
    logic           flag;
    logic [4:0]     real_number;
    logic           tok_valid;
    logic           tok_ready;
    logic [OPW-1:0] tok_operand;
    logic [2:0]     tok_op;

    modport master (
        output flag, real_number, tok_ready,
        input  tok_valid, tok_operand, tok_op
    );

    modport slave (
        input  flag, real_number, tok_ready,
        output tok_valid, tok_operand, tok_op
    );
endinterface

// File: rtl/key_token_decoder.sv
// Turns debounced keypad events into {operand, op} tokens on a valid/ready handshake.
// Optional NEG_ENTRY_EN: leading SUB marks the entry negative and adds the entry_neg port.
module key_token_decoder #(
    parameter int OPW        = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    key_token_decoder_if.slave   bus,
    output logic [OPW-1:0]       entry_value,
    output logic [3:0]           digit_cnt,
    output logic                 overflow,
    output logic                 key_drop
`ifdef NEG_ENTRY_EN
    ,
    output logic                 entry_neg
`endif
);

    typedef enum logic {S_EMPTY, S_ENTER} state_t;

    localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

    state_t         state_q, state_d;
    logic [OPW-1:0] entry_q, entry_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           drop_q, drop_d;
    logic           neg_q, neg_d;
    logic           tv_q, tv_d;
    logic [OPW-1:0] opnd_q, opnd_d;
    logic [2:0]     op_q, op_d;

    logic           key_evt;
    logic [3:0]     code;
    logic           is_digit, is_clear;
    logic           sign_key;
    logic [OPW-1:0] times10;

    assign key_evt  = bus.flag && !bus.real_number[4];
    assign code     = bus.real_number[3:0];
    assign is_digit = (code <= 4'd9);
    assign is_clear = (code == 4'd15);
    assign times10  = (entry_q << 3) + (entry_q << 1);

`ifdef NEG_ENTRY_EN
    // A SUB with nothing typed yet is a sign, not an operator (only once per entry).
    assign sign_key = (code == 4'd11) && (state_q == S_EMPTY) && !neg_q;
`else
    assign sign_key = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        drop_d  = 1'b0;
        neg_d   = neg_q;
        tv_d    = tv_q;
        opnd_d  = opnd_q;
        op_d    = op_q;

        if (tv_q && bus.tok_ready)
            tv_d = 1'b0;

        if (key_evt) begin
            if (is_digit) begin
                if (cnt_q < MAXD) begin
                    entry_d = times10 + OPW'(code);
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_ENTER;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (is_clear) begin
                entry_d = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                neg_d   = 1'b0;
                state_d = S_EMPTY;
            end else if (sign_key) begin
                neg_d = 1'b1;
            end else if (tv_q) begin
                // Release and a new issue never share a cycle, even with tok_ready high.
                drop_d = 1'b1;
            end else begin
                tv_d    = 1'b1;
                opnd_d  = neg_q ? ('0 - entry_q) : entry_q;
                op_d    = 3'(code - 4'd9);
                entry_d = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                neg_d   = 1'b0;
                state_d = S_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            entry_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
            neg_q   <= 1'b0;
            tv_q    <= 1'b0;
            opnd_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            neg_q   <= neg_d;
            tv_q    <= tv_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
        end
    end

    assign bus.tok_valid   = tv_q;
    assign bus.tok_operand = opnd_q;
    assign bus.tok_op      = op_q;
    assign entry_value     = entry_q;
    assign digit_cnt       = cnt_q;
    assign overflow        = ovf_q;
    assign key_drop        = drop_q;
`ifdef NEG_ENTRY_EN
    assign entry_neg       = neg_q;
`endif

endmodule

// File: tb/tb_key_token_decoder.sv
// Bench for key_token_decoder: directed key sequences plus random key traffic,
// every cycle compared against an integer-arithmetic calculator-entry model.
module tb_key_token_decoder;

    localparam int OPW  = 16;
    localparam int MAXD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [OPW-1:0]  entry_value;
    logic [3:0]      digit_cnt;
    logic            overflow;
    logic            key_drop;
`ifdef NEG_ENTRY_EN
    logic            entry_neg;
`endif

    key_token_decoder_if #(.OPW(OPW)) bus ();

    key_token_decoder #(.OPW(OPW), .MAX_DIGITS(MAXD)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .entry_value (entry_value),
        .digit_cnt   (digit_cnt),
        .overflow    (overflow),
        .key_drop    (key_drop)
`ifdef NEG_ENTRY_EN
        ,
        .entry_neg   (entry_neg)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int m_entry, m_cnt, m_ovf, m_drop, m_neg, m_tv, m_opnd, m_op;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit f, input int rn, input bit rdy);
        int old_tv;
        bit sgn;
        if (r) begin
            m_entry = 0; m_cnt = 0; m_ovf = 0; m_drop = 0;
            m_neg = 0; m_tv = 0; m_opnd = 0; m_op = 0;
            return;
        end
        old_tv = m_tv;
        m_drop = 0;
        if (old_tv != 0 && rdy) m_tv = 0;
        if (f && rn < 16) begin
            if (rn < 10) begin
                if (m_cnt < MAXD) begin
                    m_entry = m_entry * 10 + rn;
                    m_cnt++;
                end else m_ovf = 1;
            end else if (rn == 15) begin
                m_entry = 0; m_cnt = 0; m_ovf = 0; m_neg = 0;
            end else begin
`ifdef NEG_ENTRY_EN
                sgn = (rn == 11) && (m_cnt == 0) && (m_neg == 0);
`else
                sgn = 1'b0;
`endif
                if (sgn) m_neg = 1;
                else if (old_tv != 0) m_drop = 1;
                else begin
                    m_tv   = 1;
                    m_opnd = (m_neg != 0) ? (65536 - m_entry) % 65536 : m_entry;
                    m_op   = rn - 9;
                    m_entry = 0; m_cnt = 0; m_ovf = 0; m_neg = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("tok_valid",   32'(bus.tok_valid),   32'(m_tv));
        chk("tok_operand", 32'(bus.tok_operand), 32'(m_opnd));
        chk("tok_op",      32'(bus.tok_op),      32'(m_op));
        chk("entry_value", 32'(entry_value),     32'(m_entry));
        chk("digit_cnt",   32'(digit_cnt),       32'(m_cnt));
        chk("overflow",    32'(overflow),        32'(m_ovf));
        chk("key_drop",    32'(key_drop),        32'(m_drop));
`ifdef NEG_ENTRY_EN
        chk("entry_neg",   32'(entry_neg),       32'(m_neg));
`endif
    endtask

    // drive one cycle of inputs, advance the model at the edge, compare after it
    task automatic step(input bit r, input bit f, input int rn, input bit rdy);
        rst             = r;
        bus.flag        = f;
        bus.real_number = 5'(rn);
        bus.tok_ready   = rdy;
        @(posedge clk);
        model(r, f, rn, rdy);
        #1;
        compare_all();
    endtask

    task automatic key(input int k, input bit rdy);
        step(1'b0, 1'b1, k, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 0, rdy);
    endtask

    initial begin
        rst = 1'b1; bus.flag = 1'b0; bus.real_number = 5'd17; bus.tok_ready = 1'b0;
        step(1'b1, 1'b0, 17, 1'b0);
        chk("reset_tv", 32'(bus.tok_valid), 32'd0);
        chk("reset_entry", 32'(entry_value), 32'd0);

        // 1: 1,2,3,ADD with ready high -> one-cycle token {123,ADD}
        key(1, 1); key(2, 1); key(3, 1); key(10, 1);
        chk("t1_tv", 32'(bus.tok_valid), 32'd1);
        chk("t1_opnd", 32'(bus.tok_operand), 32'd123);
        chk("t1_op", 32'(bus.tok_op), 32'd1);
        chk("t1_entry", 32'(entry_value), 32'd0);
        idle(1);
        chk("t1_release", 32'(bus.tok_valid), 32'd0);

        // 2: fifth digit rejected, CLEAR wipes entry
        key(9, 0); key(9, 0); key(9, 0); key(9, 0); key(5, 0);
        chk("t2_entry", 32'(entry_value), 32'd9999);
        chk("t2_cnt", 32'(digit_cnt), 32'd4);
        chk("t2_ovf", 32'(overflow), 32'd1);
        key(15, 0);
        chk("t2_clr", 32'({entry_value, digit_cnt, overflow}), 32'd0);

        // 3: second operator dropped while token held; reissued after release
        key(7, 0); key(12, 0); key(4, 0); key(13, 0);
        chk("t3_drop", 32'(key_drop), 32'd1);
        chk("t3_held", 32'({bus.tok_operand, 1'b0, bus.tok_op}), 32'({16'd7, 1'b0, 3'd3}));
        chk("t3_entry", 32'(entry_value), 32'd4);
        key(13, 1);
        chk("t3_drop_rdy", 32'(key_drop), 32'd1);
        chk("t3_fall", 32'(bus.tok_valid), 32'd0);
        key(13, 0);
        chk("t3_reissue", 32'({bus.tok_operand, 1'b0, bus.tok_op}), 32'({16'd4, 1'b0, 3'd4}));
        idle(1);

        // 4: non-events
        key(6, 0);
        step(1'b0, 1'b1, 17, 0); step(1'b0, 1'b1, 16, 0); step(1'b0, 1'b0, 5, 0);
        chk("t4_entry", 32'(entry_value), 32'd6);

        // 5: reset while a token is held
        key(15, 0); key(5, 0); key(14, 0);
        chk("t5_hold", 32'(bus.tok_valid), 32'd1);
        step(1'b1, 1'b0, 0, 0);
        chk("t5_rst", 32'({bus.tok_valid, bus.tok_operand, bus.tok_op, entry_value}), 32'd0);

        // 6: leading SUB
        key(11, 0);
`ifdef NEG_ENTRY_EN
        key(4, 0); key(2, 0); key(14, 0);
        chk("t6_neg", 32'({bus.tok_operand, 1'b0, bus.tok_op}), 32'({16'hFFD6, 1'b0, 3'd5}));
`else
        chk("t6_sub", 32'({bus.tok_operand, 1'b0, bus.tok_op}), 32'({16'd0, 1'b0, 3'd2}));
        idle(1);
        key(4, 0); key(2, 0); key(14, 0);
        chk("t6_eq", 32'({bus.tok_operand, 1'b0, bus.tok_op}), 32'({16'd42, 1'b0, 3'd5}));
`endif
        idle(1);

        // random traffic: digits favoured so entries reach the digit limit
        for (int i = 0; i < 2000; i++) begin
            int  rn;
            int  sel;
            bit  f;
            sel = $urandom_range(0, 99);
            if (sel < 55)      rn = $urandom_range(0, 9);
            else if (sel < 80) rn = $urandom_range(10, 14);
            else if (sel < 88) rn = 15;
            else               rn = $urandom_range(16, 31);
            f = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 199) == 0), f, rn, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
